// File: rtl/tick_ctrl.sv
// Display clock divider with run/stop control, glitch-free stop and a
// ready/valid port that swaps the divide factor only at half-period boundaries.
module tick_ctrl #(
    parameter int          CNT_W       = 6,
    parameter int unsigned DEFAULT_DIV = 25
) (
    input  logic             clk50,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             dividedclk,
    output logic             tick,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] pend_div;
    logic             pend_vld;
    logic             wrap;
    logic             accept;

    // Both outputs decode registers only, so no input reaches them combinationally.
    assign cfg_ready = ~pend_vld;
    assign running   = (state != IDLE);
    assign wrap      = (counter >= active_div);
    assign accept    = cfg_valid & cfg_ready;

    always_ff @(posedge clk50) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            active_div <= CNT_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_vld   <= 1'b0;
            dividedclk <= 1'b0;
            tick       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    counter    <= '0;
                    dividedclk <= 1'b0;
                    tick       <= 1'b0;
                    if (cfg_valid)
                        active_div <= cfg_div;
                    if (en)
                        state <= RUN;
                end
                default: begin
                    if (!en && !dividedclk) begin
                        // Output already low: truncate the low phase, no tick.
                        state    <= IDLE;
                        counter  <= '0;
                        tick     <= 1'b0;
                        pend_vld <= 1'b0;
                        if (accept)
                            active_div <= cfg_div;
                        else if (pend_vld)
                            active_div <= pend_div;
                    end else begin
                        state <= en ? RUN : STOP;
                        if (wrap) begin
                            counter    <= '0;
                            dividedclk <= ~dividedclk;
                            tick       <= 1'b1;
                        end else begin
                            counter <= counter + CNT_W'(1);
                            tick    <= 1'b0;
                        end
                        if (wrap && pend_vld) begin
                            active_div <= pend_div;
                            pend_vld   <= 1'b0;
                        end
                        if (accept) begin
                            pend_div <= cfg_div;
                            pend_vld <= 1'b1;
                        end
                        // High phase just ended while stopping: park low in IDLE.
                        if (wrap && !en) begin
                            state    <= IDLE;
                            pend_vld <= 1'b0;
                            if (accept)
                                active_div <= cfg_div;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/tick_ctrl.md
# tick_ctrl

Run/stop and reconfiguration controller for the display clock divider. It owns the divide counter and adds three things: a ready/valid port that loads a new divide factor only at a half-period boundary, so no runt pulses reach the display logic; a glitch-free stop that always parks the divided clock low; and a one-cycle `tick` enable for logic that stays in the `clk50` domain. It sits between the game/display control logic and every consumer of the divided display clock.

## Interface
Parameters:
- `CNT_W`, default 6: width of the divide counter and of `cfg_div`.
- `DEFAULT_DIV`, default 25: divide factor loaded at reset. Half-period = `DEFAULT_DIV`+1 cycles.

Ports:
- `clk50`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `en`  in  1: run request, level-sensitive.
- `cfg_valid`  in  1: a new divide factor is offered.
- `cfg_div`  in  CNT_W: the offered divide factor; 0 is legal.
- `cfg_ready`  out  1: the block can accept a divide factor this cycle.
- `dividedclk`  out  1: divided square wave, registered.
- `tick`  out  1: one-cycle pulse on every `dividedclk` toggle, registered.
- `running`  out  1: high whenever the state is not IDLE.

## Operation
Internal registers:
- `counter[CNT_W]`, `active_div[CNT_W]`, `pend_div[CNT_W]`, `pend_vld`.
- state ∈ {IDLE, RUN, STOP}.

Reset (`rst`=1 at an edge) overrides everything:
- state=IDLE, `counter`=0, `active_div`=DEFAULT_DIV, `pend_vld`=0.
- Outputs: `dividedclk`=0, `tick`=0, `cfg_ready`=1, `running`=0.
- Reset mid-run truncates the current phase immediately and discards any pending factor.

Wrap event = state∈{RUN, STOP} and `counter` >= `active_div`. On a wrap:
- `counter`→0, `dividedclk` toggles, `tick`=1 for one cycle.
- If `pend_vld`=1: `active_div`←`pend_div` and `pend_vld`←0.

Otherwise, in RUN/STOP, `counter` increments by 1 and `tick`=0. Width is CNT_W and unsigned; wrap by overflow cannot occur because the compare is >=.

State transitions:
- IDLE → RUN when `en`=1. `counter` is held at 0 and `dividedclk` is held at 0 while in IDLE.
- RUN → STOP when `en`=0. Counting continues unchanged.
- STOP → RUN when `en`=1 again. `counter` and phase are undisturbed.
- STOP with `dividedclk`=0 → IDLE on the next edge, `counter`→0. The low phase is truncated, the output does not glitch, and no tick is issued.
- STOP with `dividedclk`=1 → keep counting. At the wrap, `dividedclk`→0, `tick`=1, then → IDLE.

Configuration handshake (a transfer happens on an edge with `cfg_valid` & `cfg_ready`):
- In IDLE: `cfg_ready`=1 and `active_div`←`cfg_div` directly. `pend_vld` is untouched and is 0 in IDLE.
- In RUN/STOP: `cfg_ready`=~`pend_vld`. The accepted value goes to `pend_div` and `pend_vld`←1. It takes effect at the next wrap.
- Accept on the same edge as a wrap: the wrap uses the old `active_div` and any earlier pending value. The new value becomes pending and applies at the following wrap.
- Once `pend_vld`=1, `cfg_ready` stays 0 until the applying wrap. It returns to 1 on the edge after that wrap.
- When STOP → IDLE with `pend_vld`=1 (dividedclk-low path): `active_div`←`pend_div` and `pend_vld`←0.
- `cfg_div` is ignored when `cfg_valid`=0.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- First wrap: `active_div`+1 edges after the edge that enters RUN. With div=25, `tick` appears 26 cycles after entry.
- Steady state: half-period = div+1 cycles, full `dividedclk` period = 2·(div+1). div=0 toggles every cycle.
- `running` rises on the IDLE→RUN edge and falls on the edge that enters IDLE.
- Stop latency from `en`=0:
  - At most `active_div`+1 cycles if `dividedclk`=1.
  - Exactly 1 cycle if `dividedclk`=0.
- Factor change latency: new half-period lengths start at the first wrap after acceptance. No half-period ever mixes two factors.

## Test plan
1. Reset, `en`=1 held → first `tick` 26 cycles after RUN entry; `dividedclk` period 52 cycles; `running`=1.
2. Running at div=25, offer `cfg_div`=9 mid-phase → current half-phase completes at 26 cycles, subsequent half-phases are 10 cycles. `cfg_ready` is low from accept until the wrap; a second offer during that window is stalled.
3. Offer `cfg_div`=3 on the exact wrap cycle → the next half-phase is still 26 cycles, and 4-cycle half-phases follow.
4. `en` dropped while `dividedclk`=1 with counter=5, div=25 → 21 more cycles, then `dividedclk`→0 with `tick`, `running`→0. `en` dropped while `dividedclk`=0 → IDLE on the next edge, no tick.
5. In IDLE, load `cfg_div`=0 then `en`=1 → `dividedclk` toggles every cycle and `tick` is held high continuously. Toggling `en` 1→0→1 within STOP keeps phase continuity.
6. Assert `rst` mid-RUN with `pend_vld`=1 → next cycle `dividedclk`=0, `tick`=0, `cfg_ready`=1, `running`=0. After `en`, half-period is 26 cycles, confirming the pending factor was discarded.
